// File: rtl/recombine_sequencer.sv
// recombine_sequencer
//   Unmasks a d-share word by running it through a narrow XOR recombination
//   path, `count` bits per cycle, then offers the unmasked word downstream.
//
//   Parameters:
//     d      shares per bit (>= 1)
//     count  bits recombined per cycle
//     width  unmasked word width (multiple of count)
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   shared word available
//     in_ready   block can accept a shared word
//     sh_in      shared word; shares of bit i at [i*d +: d]
//     out_valid  unmasked word available
//     out_ready  consumer accepts the word
//     out_data   unmasked word; bit i = XOR of the d shares of bit i
//     busy       high while recombining or holding a result
module recombine_sequencer #(
    parameter int d     = 2,
    parameter int count = 8,
    parameter int width = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width*d-1:0]   sh_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [width-1:0]     out_data,
    output logic                 busy
);

    localparam int CHUNKS = width / count;
    localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SLICE  = count * d;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [KW-1:0]       k;
    logic [width*d-1:0]  sh_reg;
    logic                armed;
    logic [SLICE-1:0]    chunk_sh;
    logic [count-1:0]    chunk_pt;
    logic                last_chunk;
    logic                accept;

    // armed keeps in_ready low until the first clock after reset release
    assign in_ready   = armed && (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign last_chunk = (k == KW'(CHUNKS - 1));

    assign chunk_sh   = sh_reg[int'(k)*SLICE +: SLICE];

    // Shared recombination path: one XOR tree per output bit of the chunk
    always_comb begin
        chunk_pt = '0;
        for (int unsigned j = 0; j < count; j++) begin
            chunk_pt[j] = ^chunk_sh[j*d +: d];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)     state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = OUT;
            OUT:     if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            k        <= '0;
            sh_reg   <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) begin
                sh_reg <= sh_in;
                k      <= '0;
            end
            if (state == RUN) begin
                out_data[int'(k)*count +: count] <= chunk_pt;
                if (!last_chunk) k <= k + KW'(1);
            end
        end
    end

endmodule
